// File: rtl/ip_trigger_capture.sv
// Trigger-armed sample capture buffer with an AVMM register file for arm/status/drain.
// Optional build macro IP_TRIGGER_CAPTURE_TIMESTAMP_EN adds the TRIG_LATENCY register at 0x14.
module ip_trigger_capture #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        S_AVST_DATA,
  input  logic              S_AVST_VALID,
  output logic              S_AVST_READY,
  input  logic [DATA_W-1:0] SENSOR_DATA,
  input  logic              SENSOR_VALID,
  input  logic              S_AVMM_R,
  output logic [31:0]       S_AVMM_RDATA,
  output logic              S_AVMM_READATAVALID,
  input  logic              S_AVMM_W,
  input  logic [31:0]       S_AVMM_WDATA,
  input  logic [7:0]        S_AVMM_ADDR,
  output logic              S_AVMM_WAITREQUEST,
  output logic              CAPTURE_DONE
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthLen = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     length_q, length_d;
  logic              underflow_q, underflow_d;
  logic              ready_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q;
  logic              buf_we;
  logic [DATA_W-1:0] buf_mem [DEPTH];

  logic          wr_ctrl, arm, clr, wr_len, rd_data, trigger;
  logic [CW-1:0] eff_len;

  assign wr_ctrl = S_AVMM_W && (S_AVMM_ADDR == 8'h00);
  assign arm     = wr_ctrl && S_AVMM_WDATA[0];
  assign clr     = wr_ctrl && S_AVMM_WDATA[1];
  assign wr_len  = S_AVMM_W && (S_AVMM_ADDR == 8'h10);
  assign rd_data = S_AVMM_R && (S_AVMM_ADDR == 8'h0C);
  assign trigger = S_AVST_VALID && ready_q && S_AVST_DATA[0];

  // Zero or oversize lengths fall back to a full-buffer capture.
  assign eff_len = ((length_q == '0) || (length_q > DepthLen)) ? DepthLen : length_q;

  logic unused_bits;
  assign unused_bits = ^{S_AVST_DATA[7:1], S_AVMM_WDATA[31:CW]};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    length_d    = length_q;
    underflow_d = underflow_q;
    buf_we      = 1'b0;

    if (wr_len && (state_q == StIdle)) length_d = S_AVMM_WDATA[CW-1:0];
    if (rd_data && (state_q != StDone)) underflow_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (arm) state_d = StArmed;
      end
      StArmed: begin
        if (trigger) begin
          state_d = StCapture;
          count_d = '0;
        end
      end
      StCapture: begin
        if (SENSOR_VALID) begin
          buf_we  = 1'b1;
          count_d = count_q + CW'(1);
          if ((count_q + CW'(1)) == eff_len) state_d = StDone;
        end
      end
      StDone: begin
        if (rd_data) begin
          rd_ptr_d = rd_ptr_q + CW'(1);
          if ((rd_ptr_q + CW'(1)) == count_q) begin
            state_d  = StIdle;
            rd_ptr_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      state_d     = StIdle;
      count_d     = '0;
      rd_ptr_d    = '0;
      underflow_d = 1'b0;
    end
  end

`ifdef IP_TRIGGER_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_q, ts_d, trig_lat_q, trig_lat_d;

  always_comb begin
    ts_d       = ts_q;
    trig_lat_d = trig_lat_q;
    if ((state_q == StIdle) && arm && !clr) begin
      ts_d = '0;
    end else if (ts_q != 32'hFFFF_FFFF) begin
      ts_d = ts_q + 32'd1;
    end
    if ((state_q == StArmed) && trigger && !clr) trig_lat_d = ts_q;
    if (clr) trig_lat_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      trig_lat_q <= '0;
    end else begin
      ts_q       <= ts_d;
      trig_lat_q <= trig_lat_d;
    end
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (S_AVMM_R) begin
      case (S_AVMM_ADDR)
        8'h04: rdata_d = {27'd0, underflow_q, 2'b00, state_q};
        8'h08: rdata_d = 32'(count_q);
        8'h0C: if (state_q == StDone) rdata_d = 32'(buf_mem[rd_ptr_q[AW-1:0]]);
        8'h10: rdata_d = 32'(length_q);
`ifdef IP_TRIGGER_CAPTURE_TIMESTAMP_EN
        8'h14: rdata_d = trig_lat_q;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      length_q    <= DepthLen;
      underflow_q <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      length_q    <= length_d;
      underflow_q <= underflow_d;
      ready_q     <= 1'b1;
      rdata_q     <= rdata_d;
      rvalid_q    <= S_AVMM_R;
    end
  end

  // Buffer contents are not reset; they are only read back after a fresh capture.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[count_q[AW-1:0]] <= SENSOR_DATA;
  end

  assign S_AVST_READY        = ready_q;
  assign S_AVMM_RDATA        = rdata_q;
  assign S_AVMM_READATAVALID = rvalid_q;
  assign S_AVMM_WAITREQUEST  = 1'b0;
  assign CAPTURE_DONE        = (state_q == StDone);

endmodule

// File: doc/ip_trigger_capture.md
Name: ip_trigger_capture

Overview:
- Sits directly downstream of the trigger-sync stage and consumes its 8-bit AVST trigger stream (bit0 = trigger pulse).
- When armed, a trigger starts a capture of a fixed number of sensor samples into an internal buffer.
- Software arms the block, reads status and drains the captured samples through an AVMM slave register file.

Parameters:
- DATA_W, 16, sensor sample width (1..32).
- DEPTH, 256, capture buffer depth in samples (power of two, 2..1024).
- AW, $clog2(DEPTH), buffer address width (derived, not overridden).

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- S_AVST_DATA  in  8  trigger stream; bit0 = trigger, bits[7:1] ignored.
- S_AVST_VALID  in  1  trigger stream valid.
- S_AVST_READY  out  1  trigger stream ready.
- SENSOR_DATA  in  DATA_W  sensor sample.
- SENSOR_VALID  in  1  sample strobe.
- S_AVMM_R  in  1  read strobe.
- S_AVMM_RDATA  out  32  read data.
- S_AVMM_READATAVALID  out  1  read data valid.
- S_AVMM_W  in  1  write strobe.
- S_AVMM_WDATA  in  32  write data.
- S_AVMM_ADDR  in  8  byte address.
- S_AVMM_WAITREQUEST  out  1  tied 0; the slave never stalls.
- CAPTURE_DONE  out  1  level output, high in DONE.

Behaviour:
- Reset values: S_AVST_READY=0, S_AVMM_RDATA=0, S_AVMM_READATAVALID=0, CAPTURE_DONE=0, state=IDLE, COUNT=0, rd_ptr=0, LENGTH=DEPTH, flags=0.
- S_AVST_READY goes to 1 on the first clock after reset release and stays 1. A trigger is S_AVST_VALID & S_AVST_READY & S_AVST_DATA[0].
- Register map (32-bit, unused bits read 0):
  - 0x00 CTRL, W: bit0 ARM, bit1 CLEAR. Reads return 0.
  - 0x04 STATUS, R: [1:0] state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3), bit4 underflow sticky.
  - 0x08 COUNT, R: samples stored.
  - 0x0C DATA, R: pops the next sample, zero-extended.
  - 0x10 LENGTH, RW: capture length, AW+1 bits.
- Reads have a fixed latency of 1: S_AVMM_R in cycle N gives S_AVMM_READATAVALID=1 with data in cycle N+1. Unmapped addresses return 0.
- FSM transitions:
  - IDLE: ARM write -> ARMED. The trigger is ignored.
  - ARMED: trigger -> CAPTURE, COUNT cleared.
  - CAPTURE: each SENSOR_VALID writes buf[COUNT] and increments COUNT. When COUNT reaches the effective length -> DONE. The sample in the trigger cycle itself is not captured; the first sample is the first SENSOR_VALID in the cycle after the trigger.
  - DONE: CAPTURE_DONE=1; DATA reads pop buf[rd_ptr], rd_ptr++. When rd_ptr==COUNT after a pop -> IDLE, rd_ptr=0, CAPTURE_DONE=0 next cycle.
- CLEAR in any state -> IDLE next cycle, with COUNT=0, rd_ptr=0 and underflow=0. CLEAR has priority over ARM in the same write.
- ARM written in a state other than IDLE is ignored.
- An ARM write and a trigger in the same cycle: the block enters ARMED and that trigger is dropped.
- Effective length: LENGTH=0 or LENGTH>DEPTH is treated as DEPTH. LENGTH writes are ignored outside IDLE.
- DATA read outside DONE returns 0, does not move rd_ptr, and sets underflow.
- Triggers during CAPTURE or DONE are ignored (a trigger is not retriggerable).
- Reset assertion mid-capture returns the block to reset values immediately. Buffer contents are undefined after that.

Optional Feature:
- Macro: IP_TRIGGER_CAPTURE_TIMESTAMP_EN.
- When defined:
  - A 32-bit cycle counter runs from the ARMED entry, cleared on entering ARMED and saturating at 0xFFFFFFFF.
  - The count is latched into 0x14 TRIG_LATENCY (R) on the trigger.
  - CLEAR zeroes TRIG_LATENCY.
- When undefined: no counter logic is built and 0x14 reads 0.

Test Plan:
- Reset, then read STATUS -> 0x0. S_AVST_READY=1 one cycle after reset release. CAPTURE_DONE=0.
- LENGTH=4, ARM, trigger (DATA=0x01), SENSOR_VALID with 0x11,0x22,0x33,0x44,0x55 -> STATUS state=3, COUNT=4. Four DATA reads return 0x11..0x44, each with READATAVALID exactly one cycle after the read. Final state is IDLE.
- Trigger while IDLE, and S_AVST_DATA=0xFE with valid while ARMED -> state unchanged (0 and 1 respectively).
- ARMED, trigger, 2 samples, CLEAR -> STATUS=0, COUNT=0. A DATA read returns 0 and STATUS bit4=1.
- LENGTH=0 with DEPTH=256 -> capture stops at COUNT=256. The reset pulse mid-CAPTURE returns STATUS=0 and COUNT=0 immediately.
- With TIMESTAMP_EN: ARM, trigger 10 cycles later -> TRIG_LATENCY=10. Without TIMESTAMP_EN: 0x14 reads 0.
